// File: rtl/mult_booth_seq_pkg.sv
// Shared constants for the sequential radix-2 Booth multiplier:
// operand width, iteration counter width, FSM encodings and Booth decode.
package mult_booth_seq_pkg;

    localparam int WIDTH      = 32;
    localparam int ITER_CNT_W = 5;
    localparam int P_W        = 2 * WIDTH + 1;  // {A, Q, q-1}

    // FSM state encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Booth decode of {Q[0], q-1}
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mult_booth_seq_addsub.sv
// booth_addsub: combinational 33-bit add/subtract of the partial-product
// high word A and the multiplicand M, selected by the two Booth bits.
// Both operands are sign-extended to 33 bits so the sum never wraps.
module booth_addsub
    import mult_booth_seq_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] m_i,
    input  logic [1:0]       booth_i,
    output logic [WIDTH:0]   sum_o
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] m_ext;

    assign a_ext = {a_i[WIDTH-1], a_i};
    assign m_ext = {m_i[WIDTH-1], m_i};

    // Select A+M, A-M or pass A through depending on the Booth pair.
    always_comb begin
        // NOTE: assigning a default first means every path drives sum_o,
        // so no latch is inferred for the 00/11 cases.
        sum_o = a_ext;
        case (booth_i)
            BOOTH_ADD: sum_o = a_ext + m_ext;
            BOOTH_SUB: sum_o = a_ext + ~m_ext + {{WIDTH{1'b0}}, 1'b1};
            default:   sum_o = a_ext;
        endcase
    end

endmodule

// File: rtl/mult_booth_seq.sv
// mult_booth_seq: sequential 32x32 signed radix-2 Booth multiplier, one
// add/shift iteration per clock. Returns the low word of the product with
// a one-cycle ready pulse. Defining MULT_OVF_DETECT_EN enables the
// signed-overflow exception; otherwise data_exception is tied low.
module mult_booth_seq
    import mult_booth_seq_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_mult,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    logic [1:0]            state_q,  state_d;
    logic [P_W-1:0]        p_q,      p_d;
    logic [WIDTH-1:0]      m_q,      m_d;
    logic [ITER_CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0]      result_q, result_d;
    logic                  exc_q,    exc_d;

    logic [WIDTH:0]        sum_w;
    logic [P_W-1:0]        p_shift;
    logic                  ovf_w;

    booth_addsub u_addsub (
        .a_i     (p_q[P_W-1 -: WIDTH]),
        .m_i     (m_q),
        .booth_i (p_q[1:0]),
        .sum_o   (sum_w)
    );

    // The 33-bit sum supplies its own sign bit, so dropping the LSB of the
    // 66-bit {sum, Q, q-1} is the arithmetic right shift of P.
    assign p_shift = {sum_w[WIDTH:1], sum_w[0], p_q[WIDTH:2], p_q[1]};

`ifdef MULT_OVF_DETECT_EN
    // Overflow when the high word is not the sign extension of the low word.
    assign ovf_w = (p_shift[P_W-1 -: WIDTH] != {WIDTH{p_shift[WIDTH]}});
`else
    assign ovf_w = 1'b0;
`endif

    // Next-state logic: start/restart, Booth iteration and result capture.
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        case (state_q)
            IDLE, DONE: begin
                if (ctrl_mult) begin
                    m_d     = data_operandA;
                    p_d     = {{WIDTH{1'b0}}, data_operandB, 1'b0};
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                p_d   = p_shift;
                cnt_d = cnt_q + {{(ITER_CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == ITER_CNT_W'(WIDTH - 1)) begin
                    state_d  = DONE;
                    result_d = p_shift[WIDTH:1];
                    exc_d    = ovf_w;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments make every register update from
        // the values sampled at the same edge, independent of order.
        if (!reset_n) begin
            state_q  <= IDLE;
            p_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed testbench for mult_booth_seq: hand-computed products, latency,
// ignored restart, back-to-back start and mid-run reset.
module tb_mult_booth_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_mult;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

`ifdef MULT_OVF_DETECT_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    mult_booth_seq dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_mult      (ctrl_mult),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Start edge E0; returns #1 after E0 with ctrl_mult dropped.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        ctrl_mult     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        tick();
        ctrl_mult = 1'b0;
    endtask

    // Wait (bounded) for ready; 'done' edges have already passed since E0.
    task automatic wait_result(input string tag, input int done,
                               input logic [31:0] exp_res, input logic exp_exc);
        int n = done;
        while (!data_resultRDY && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 32);
        check({tag, "_result"}, data_result, exp_res);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int rdy_seen;
        reset_n       = 1'b0;
        ctrl_mult     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        tick();
        tick();
        check("rst_result", data_result, 32'd0);
        check("rst_exc", {31'd0, data_exception}, 32'd0);
        check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        tick();

        // 3 x 4
        start(32'd3, 32'd4);
        check("m3x4_busy", {31'd0, busy}, 32'd1);
        wait_result("m3x4", 0, 32'h0000000C, 1'b0);
        tick();
        check("m3x4_rdy_pulse", {31'd0, data_resultRDY}, 32'd0);
        check("m3x4_hold", data_result, 32'h0000000C);

        // -7 x 6
        start(32'hFFFFFFF9, 32'd6);
        wait_result("m7x6", 0, 32'hFFFFFFD6, 1'b0);
        tick();

        // Restart attempt at cycle 10 of RUN is ignored; operands changed too
        start(32'd5, 32'd7);
        repeat (10) tick();
        check("ign_result_held", data_result, 32'hFFFFFFD6);
        ctrl_mult     = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd100;
        tick();
        ctrl_mult = 1'b0;
        check("ign_busy", {31'd0, busy}, 32'd1);
        wait_result("ign", 11, 32'd35, 1'b0);

        // Back-to-back start in the DONE cycle: -3 x -5
        start(32'hFFFFFFFD, 32'hFFFFFFFB);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_result_held", data_result, 32'd35);
        wait_result("b2b", 0, 32'd15, 1'b0);
        tick();

        // Reset at cycle 15 of RUN aborts and clears the result
        start(32'd9, 32'd9);
        repeat (15) tick();
        reset_n = 1'b0;
        tick();
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_result", data_result, 32'd0);
        check("mrst_rdy", {31'd0, data_resultRDY}, 32'd0);
        reset_n  = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (data_resultRDY) rdy_seen++;
        end
        check("mrst_no_rdy", rdy_seen, 32'd0);

        // Overflow cases
        start(32'h7FFFFFFF, 32'd2);
        wait_result("ovf_max2", 0, 32'hFFFFFFFE, OVF);
        tick();
        start(32'h80000000, 32'hFFFFFFFF);
        wait_result("ovf_minneg1", 0, 32'h80000000, OVF);
        tick();
        start(32'h00010000, 32'h00010000);
        wait_result("ovf_2p32", 0, 32'h00000000, OVF);
        tick();
        check("ovf_exc_held", {31'd0, data_exception}, {31'd0, OVF});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
